// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between the
// instruction-fetch and load/store ports, round-robin on contention.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_e      state_q;
    logic        win_data_d;
    logic        win_data_q;
    logic        last_data_q;
    logic [3:0]  we_q;
    logic [3:0]  cnt_q;
    logic        mem_en_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_we_q;
    logic [31:0] mem_wdata_q;
    logic        i_ack_q;
    logic        d_ack_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    // Data wins when it is alone, or on contention when instr was granted last.
    always_comb begin
        win_data_d = d_req && (!i_req || !last_data_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 4'h0;
            cnt_q       <= 4'h0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            mem_en_q <= 1'b0;
            mem_we_q <= 4'h0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q     <= ISSUE;
                        win_data_q  <= win_data_d;
                        last_data_q <= win_data_d;
                        mem_en_q    <= 1'b1;
                        if (win_data_d) begin
                            mem_addr_q  <= d_addr;
                            mem_we_q    <= d_we;
                            we_q        <= d_we;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_addr_q <= i_addr;
                            we_q       <= 4'h0;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= LAT_M1;
                end
                WAIT: begin
                    if (cnt_q == 4'h0) begin
                        state_q <= DONE;
                        if (win_data_q) begin
                            d_ack_q <= 1'b1;
                            if (we_q == 4'h0) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else begin
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'h1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
